// File: rtl/stage_fetch_if.sv
// Fetch-stage bus bundle: hazard/redirect inputs, imem port, IF/ID latch and debug counters.
interface stage_fetch_if #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 stall;
    logic                 ex_redirect;
    logic [31:0]          ex_target;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [31:0]          imem_q;
    logic [31:0]          ifid_insn;
    logic [31:0]          ifid_pc_plus_4;
    logic                 ifid_valid;
    logic                 flush_idex;
    logic [CNT_WIDTH-1:0] redirect_count;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        input  stall, ex_redirect, ex_target, imem_q,
        output imem_addr, ifid_insn, ifid_pc_plus_4, ifid_valid, flush_idex,
               redirect_count, stall_count
    );

    modport slave (
        output stall, ex_redirect, ex_target, imem_q,
        input  imem_addr, ifid_insn, ifid_pc_plus_4, ifid_valid, flush_idex,
               redirect_count, stall_count
    );
endinterface

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem and fills IF/ID,
// squashing wrong-path slots on execute-stage redirects.
module stage_fetch #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    stage_fetch_if.master bus
);
    localparam logic [PC_WIDTH-1:0]  PC_RST  = PC_WIDTH'(RESET_PC);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]  pc_plus_one;
    logic [31:0]          ifid_insn_q, ifid_insn_d;
    logic [31:0]          ifid_pc_plus_4_q, ifid_pc_plus_4_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    assign pc_plus_one = fetch_pc_q + PC_WIDTH'(1);

    // Priority: reset, redirect, stall, sequential. Redirect beats stall.
    always_comb begin
        fetch_pc_d       = pc_plus_one;
        ifid_insn_d      = bus.imem_q;
        ifid_pc_plus_4_d = 32'(pc_plus_one);
        ifid_valid_d     = 1'b1;
        redirect_count_d = redirect_count_q;
        stall_count_d    = stall_count_q;

        if (!reset) begin
            fetch_pc_d       = PC_RST;
            ifid_insn_d      = 32'd0;
            ifid_pc_plus_4_d = 32'd0;
            ifid_valid_d     = 1'b0;
            redirect_count_d = '0;
            stall_count_d    = '0;
        end else if (bus.ex_redirect) begin
            fetch_pc_d       = bus.ex_target[PC_WIDTH-1:0];
            ifid_insn_d      = 32'd0;
            ifid_pc_plus_4_d = ifid_pc_plus_4_q;
            ifid_valid_d     = 1'b0;
            if (redirect_count_q != CNT_MAX) begin
                redirect_count_d = redirect_count_q + CNT_WIDTH'(1);
            end
        end else if (bus.stall) begin
            fetch_pc_d       = fetch_pc_q;
            ifid_insn_d      = ifid_insn_q;
            ifid_pc_plus_4_d = ifid_pc_plus_4_q;
            ifid_valid_d     = ifid_valid_q;
            if (stall_count_q != CNT_MAX) begin
                stall_count_d = stall_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q       <= PC_RST;
            ifid_insn_q      <= 32'd0;
            ifid_pc_plus_4_q <= 32'd0;
            ifid_valid_q     <= 1'b0;
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            ifid_insn_q      <= ifid_insn_d;
            ifid_pc_plus_4_q <= ifid_pc_plus_4_d;
            ifid_valid_q     <= ifid_valid_d;
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    // imem registers its address on the same edge that loads fetch_pc, so imem_q tracks mem[fetch_pc].
    assign bus.imem_addr      = fetch_pc_d;
    assign bus.flush_idex     = bus.ex_redirect & reset;
    assign bus.ifid_insn      = ifid_insn_q;
    assign bus.ifid_pc_plus_4 = ifid_pc_plus_4_q;
    assign bus.ifid_valid     = ifid_valid_q;
    assign bus.redirect_count = redirect_count_q;
    assign bus.stall_count    = stall_count_q;
endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: a behavioural PC/IF-ID model pushes expectations to a scoreboard
// popped after each edge; scenario tasks add targeted checks. A 2-bit-counter copy tracks saturation.
module tb_stage_fetch;
    localparam int unsigned RESET_PC = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] rc;
        logic [15:0] sc;
        logic [1:0]  sc2;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    stage_fetch_if #(.PC_WIDTH(12), .CNT_WIDTH(16)) bus ();
    stage_fetch_if #(.PC_WIDTH(12), .CNT_WIDTH(2))  bus_s ();

    stage_fetch #(.PC_WIDTH(12), .RESET_PC(RESET_PC), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    stage_fetch #(.PC_WIDTH(12), .RESET_PC(RESET_PC), .CNT_WIDTH(2)) u_dut_small (
        .clock(clock), .reset(reset), .bus(bus_s)
    );

    assign bus_s.stall       = bus.stall;
    assign bus_s.ex_redirect = bus.ex_redirect;
    assign bus_s.ex_target   = bus.ex_target;

    always #5 clock = ~clock;

    logic [31:0] mem [4096];
    always @(posedge clock) begin
        bus.imem_q   <= mem[bus.imem_addr];
        bus_s.imem_q <= mem[bus_s.imem_addr];
    end

    // reference model state
    logic [11:0] m_pc;
    logic [31:0] m_insn, m_pc4;
    logic        m_valid;
    logic [15:0] m_rc, m_sc;
    logic [1:0]  m_sc2;
    exp_t        sb[$];
    exp_t        got;

    // scoreboard monitor: compare IF/ID and counters just after each edge
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            got = sb.pop_front();
            n_checks++;
            if (bus.ifid_insn !== got.insn) begin
                n_fail++; $display("FAIL sb_insn got=%h exp=%h t=%0t", bus.ifid_insn, got.insn, $time);
            end
            n_checks++;
            if (bus.ifid_pc_plus_4 !== got.pc4) begin
                n_fail++; $display("FAIL sb_pc4 got=%h exp=%h t=%0t", bus.ifid_pc_plus_4, got.pc4, $time);
            end
            n_checks++;
            if (bus.ifid_valid !== got.valid) begin
                n_fail++; $display("FAIL sb_valid got=%b exp=%b t=%0t", bus.ifid_valid, got.valid, $time);
            end
            n_checks++;
            if (bus.redirect_count !== got.rc) begin
                n_fail++; $display("FAIL sb_redirect_count got=%0d exp=%0d t=%0t", bus.redirect_count, got.rc, $time);
            end
            n_checks++;
            if (bus.stall_count !== got.sc) begin
                n_fail++; $display("FAIL sb_stall_count got=%0d exp=%0d t=%0t", bus.stall_count, got.sc, $time);
            end
            n_checks++;
            if (bus_s.stall_count !== got.sc2) begin
                n_fail++; $display("FAIL sb_stall_count_sat got=%0d exp=%0d t=%0t", bus_s.stall_count, got.sc2, $time);
            end
        end
    end

    // Drive one cycle's inputs, check the combinational outputs, queue the post-edge expectation.
    task automatic drive(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        logic [11:0] nxt;
        exp_t        e;
        @(negedge clock);
        reset = rst; bus.stall = st; bus.ex_redirect = rd; bus.ex_target = tgt;
        #1;
        if (!rst) begin
            nxt = 12'(RESET_PC); m_insn = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            m_rc = 16'd0; m_sc = 16'd0; m_sc2 = 2'd0;
        end else if (rd) begin
            nxt = tgt[11:0]; m_insn = 32'd0; m_valid = 1'b0;
            if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
        end else if (st) begin
            nxt = m_pc;
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (m_sc2 != 2'b11) m_sc2 = m_sc2 + 2'd1;
        end else begin
            nxt = m_pc + 12'd1; m_insn = 32'h1000 + 32'(m_pc); m_pc4 = 32'(nxt); m_valid = 1'b1;
        end
        n_checks++;
        if (bus.imem_addr !== nxt) begin
            n_fail++; $display("FAIL imem_addr got=%h exp=%h t=%0t", bus.imem_addr, nxt, $time);
        end
        n_checks++;
        if (bus.flush_idex !== (rd & rst)) begin
            n_fail++; $display("FAIL flush_idex got=%b exp=%b t=%0t", bus.flush_idex, rd & rst, $time);
        end
        m_pc = nxt;
        e.insn = m_insn; e.pc4 = m_pc4; e.valid = m_valid; e.rc = m_rc; e.sc = m_sc; e.sc2 = m_sc2;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h55);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_valid !== 1'b0 || bus.ifid_insn !== 32'd0 || bus.stall_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_state valid=%b insn=%h sc=%0d exp 0/0/0",
                               bus.ifid_valid, bus.ifid_insn, bus.stall_count);
        end
    endtask

    task automatic test_sequential_and_stall();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_insn !== 32'h1002 || bus.stall_count !== 16'd2) begin
            n_fail++; $display("FAIL stall_hold insn=%h sc=%0d exp 00001002/2", bus.ifid_insn, bus.stall_count);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_insn !== 32'h1003 || bus.ifid_pc_plus_4 !== 32'd4) begin
            n_fail++; $display("FAIL stall_release insn=%h pc4=%h exp 00001003/4", bus.ifid_insn, bus.ifid_pc_plus_4);
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_insn !== 32'h1040 || bus.ifid_pc_plus_4 !== 32'h41 || bus.redirect_count !== 16'd1) begin
            n_fail++; $display("FAIL redirect_target insn=%h pc4=%h rc=%0d exp 00001040/41/1",
                               bus.ifid_insn, bus.ifid_pc_plus_4, bus.redirect_count);
        end
    endtask

    task automatic test_redirect_over_stall();
        logic [15:0] sc0;
        sc0 = bus.stall_count;
        drive(1'b1, 1'b1, 1'b1, 32'hA0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_F0A0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_insn !== 32'h10A0 || bus.stall_count !== sc0) begin
            n_fail++; $display("FAIL redirect_over_stall insn=%h sc=%0d exp 000010a0/%0d",
                               bus.ifid_insn, bus.stall_count, sc0);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 1'b1, 32'hFFE);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_insn !== 32'h1000 || bus.ifid_pc_plus_4 !== 32'h1) begin
            n_fail++; $display("FAIL pc_wrap insn=%h pc4=%h exp 00001000/1", bus.ifid_insn, bus.ifid_pc_plus_4);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rc0;
        rc0 = bus.redirect_count;
        drive(1'b1, 1'b0, 1'b1, 32'h10);
        drive(1'b1, 1'b0, 1'b1, 32'h20);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_insn !== 32'h1020 || bus.redirect_count !== rc0 + 16'd2) begin
            n_fail++; $display("FAIL back_to_back insn=%h rc=%0d exp 00001020/%0d",
                               bus.ifid_insn, bus.redirect_count, rc0 + 16'd2);
        end
    endtask

    task automatic test_reset_mid_and_saturate();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus.ifid_valid !== 1'b0 || bus.ifid_pc_plus_4 !== 32'd0 || bus.redirect_count !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset valid=%b pc4=%h rc=%0d exp 0/0/0",
                               bus.ifid_valid, bus.ifid_pc_plus_4, bus.redirect_count);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 32'd0);
        @(posedge clock); #2;
        n_checks++;
        if (bus_s.stall_count !== 2'd3 || bus.stall_count !== 16'd6) begin
            n_fail++; $display("FAIL stall_saturate small=%0d wide=%0d exp 3/6", bus_s.stall_count, bus.stall_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000 + 32'(i);
        reset = 1'b0; bus.stall = 1'b0; bus.ex_redirect = 1'b0; bus.ex_target = 32'd0;
        m_pc = 12'd0; m_insn = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        m_rc = 16'd0; m_sc = 16'd0; m_sc2 = 2'd0;

        test_reset();
        test_sequential_and_stall();
        test_redirect();
        test_redirect_over_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid_and_saturate();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clock);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain left=%0d exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
